// File: rtl/fu_result_queue.sv
// rtl/fu_result_queue.sv - per-FU in-order result buffer feeding the CDB prepared/avail handshake
//
// Purpose: queues completed results from one functional unit and presents the
// oldest one to the CDB arbiter. The head is popped when the CDB reports the
// slot available; enq_ready back-pressures the FU when the buffer is full.
//
// Ports:
//   clock       sole clock, all state updates on posedge
//   reset       asynchronous active-high, clears head/tail/count
//   squash      synchronous flush, discards every entry (wins over enq/deq)
//   enq_valid   FU presents a completed result this cycle
//   enq_packet  result packet from the FU
//   enq_ready   queue accepts an enqueue this cycle (registered count only)
//   prepared    head entry valid
//   out_packet  head entry, zero when empty
//   avail       CDB consumes the head at this edge when prepared
//   count       current occupancy, 0..DEPTH

module fu_result_queue #(
    parameter int DEPTH     = 4,
    parameter int PKT_WIDTH = 64,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 enq_valid,
    input  logic [PKT_WIDTH-1:0] enq_packet,
    output logic                 enq_ready,
    output logic                 prepared,
    output logic [PKT_WIDTH-1:0] out_packet,
    input  logic                 avail,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [PKT_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0] head;
    logic [PTR_WIDTH-1:0] tail;
    logic                 enq_fire;
    logic                 deq_fire;
    logic [CNT_WIDTH-1:0] count_next;

    // enq_ready looks only at the registered count, so a pop in the same
    // cycle never frees a slot combinationally (no avail -> FU stall path).
    assign enq_ready  = (count != FULL_COUNT);
    assign prepared   = (count != '0);
    assign out_packet = prepared ? mem[head] : '0;

    assign enq_fire = enq_valid & enq_ready & ~squash;
    assign deq_fire = avail & prepared & ~squash;

    always_comb begin
        count_next = count;
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count + CNT_WIDTH'(1);
            2'b01:   count_next = count - CNT_WIDTH'(1);
            default: count_next = count;
        endcase
    end

    // Pointer and occupancy state. DEPTH is a power of two, so the natural
    // pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_WIDTH'(1);
            end
            if (deq_fire) begin
                head <= head + PTR_WIDTH'(1);
            end
            count <= count_next;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (enq_fire) begin
            mem[tail] <= enq_packet;
        end
    end

endmodule

// File: tb/tb_fu_result_queue.sv
// tb/tb_fu_result_queue.sv - self-checking bench for fu_result_queue

module tb_fu_result_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 64;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          squash = 1'b0;
    logic          enq_valid = 1'b0;
    logic [PW-1:0] enq_packet = '0;
    logic          enq_ready;
    logic          prepared;
    logic [PW-1:0] out_packet;
    logic          avail = 1'b0;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] model [$];

    fu_result_queue #(.DEPTH(DEPTH), .PKT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .squash     (squash),
        .enq_valid  (enq_valid),
        .enq_packet (enq_packet),
        .enq_ready  (enq_ready),
        .prepared   (prepared),
        .out_packet (out_packet),
        .avail      (avail),
        .count      (count)
    );

    always #5 clock = ~clock;

    function automatic logic [CW-1:0] exp_count();
        return CW'(model.size());
    endfunction

    function automatic logic [PW-1:0] exp_out();
        if (model.size() == 0) return '0;
        return model[0];
    endfunction

    // Advance one clock edge and update the reference queue from the inputs
    // that were present before the edge.
    task automatic tick();
        bit            do_enq;
        bit            do_deq;
        logic [PW-1:0] pkt;
        do_enq = enq_valid && (model.size() != DEPTH) && !squash;
        do_deq = avail && (model.size() != 0) && !squash;
        pkt    = enq_packet;
        @(posedge clock);
        #1;
        if (squash) begin
            model.delete();
        end else begin
            if (do_deq) void'(model.pop_front());
            if (do_enq) model.push_back(pkt);
        end
    endtask

    task automatic flush();
        squash = 1'b1; enq_valid = 1'b0; avail = 1'b0;
        tick();
        squash = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++;
        if (prepared !== 1'b0 || out_packet !== '0 || enq_ready !== 1'b1 || count !== '0) begin
            bad++;
            $display("FAIL reset_state: prepared=%b out=%h ready=%b count=%0d want 0/0/1/0",
                     prepared, out_packet, enq_ready, count);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        model.delete();
    endtask

    task automatic test_in_order_fill();
        logic [PW-1:0] pk [3];
        pk[0] = 64'h11; pk[1] = 64'h22; pk[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_packet = pk[i];
            tick();
            total++;
            if (count !== CW'(i + 1) || prepared !== 1'b1 || out_packet !== 64'h11) begin
                bad++;
                $display("FAIL fill_step%0d: count=%0d prepared=%b out=%h want %0d/1/11",
                         i, count, prepared, out_packet, i + 1);
            end
        end
        enq_valid = 1'b0;
        flush();
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            enq_valid = 1'b1; enq_packet = PW'(8'hA0 + i);
            tick();
        end
        enq_packet = 64'hAB;
        tick();
        total++;
        if (count !== CW'(DEPTH) || enq_ready !== 1'b0 || count !== exp_count()) begin
            bad++;
            $display("FAIL full_hold: count=%0d ready=%b want %0d/0", count, enq_ready, DEPTH);
        end
        avail = 1'b1;
        tick();
        avail = 1'b0;
        total++;
        if (count !== CW'(DEPTH - 1) || enq_ready !== 1'b1 || out_packet !== 64'hA1) begin
            bad++;
            $display("FAIL full_pop: count=%0d ready=%b out=%h want 3/1/a1", count, enq_ready, out_packet);
        end
        tick();
        enq_valid = 1'b0;
        total++;
        if (count !== CW'(DEPTH) || model[DEPTH-1] !== 64'hAB || count !== exp_count()) begin
            bad++;
            $display("FAIL full_accept: count=%0d want %0d", count, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            avail = 1'b1;
            tick();
            total++;
            if (out_packet !== exp_out() || count !== exp_count()) begin
                bad++;
                $display("FAIL full_drain%0d: out=%h count=%0d want %h/%0d",
                         i, out_packet, count, exp_out(), exp_count());
            end
        end
        avail = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 10; i++) begin
            enq_valid = 1'b1; avail = 1'b1; enq_packet = PW'(i);
            tick();
            total++;
            if (out_packet !== PW'(i) || count !== CW'(1) || prepared !== 1'b1) begin
                bad++;
                $display("FAIL b2b_%0d: out=%h count=%0d prepared=%b want %h/1/1",
                         i, out_packet, count, prepared, i);
            end
        end
        enq_valid = 1'b0;
        tick();
        avail = 1'b0;
        total++;
        if (count !== '0 || prepared !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: count=%0d prepared=%b want 0/0", count, prepared);
        end
    endtask

    task automatic test_squash();
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_packet = PW'(8'hC0 + i);
            tick();
        end
        enq_packet = 64'h77; squash = 1'b1; avail = 1'b1;
        tick();
        squash = 1'b0; enq_valid = 1'b0; avail = 1'b0;
        total++;
        if (count !== '0 || prepared !== 1'b0 || out_packet !== '0) begin
            bad++;
            $display("FAIL squash: count=%0d prepared=%b out=%h want 0/0/0", count, prepared, out_packet);
        end
        avail = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_packet === 64'h77 || prepared !== 1'b0) begin
                bad++;
                $display("FAIL squash_leak%0d: out=%h prepared=%b want 0/0", i, out_packet, prepared);
            end
        end
        avail = 1'b0;
    endtask

    task automatic test_async_reset();
        enq_valid = 1'b1; enq_packet = 64'hD1; tick();
        enq_packet = 64'hD2; tick();
        enq_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (prepared !== 1'b0 || out_packet !== '0 || enq_ready !== 1'b1 || count !== '0) begin
            bad++;
            $display("FAIL async_reset: prepared=%b out=%h ready=%b count=%0d want 0/0/1/0",
                     prepared, out_packet, enq_ready, count);
        end
        model.delete();
        #2;
        reset = 1'b0;
        enq_valid = 1'b1; enq_packet = 64'h5A;
        tick();
        enq_valid = 1'b0;
        total++;
        if (count !== CW'(1) || out_packet !== 64'h5A || prepared !== 1'b1) begin
            bad++;
            $display("FAIL after_reset: count=%0d out=%h prepared=%b want 1/5a/1", count, out_packet, prepared);
        end
        flush();
    endtask

    task automatic test_empty_avail();
        avail = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (count !== '0 || prepared !== 1'b0 || out_packet !== '0) begin
                bad++;
                $display("FAIL empty_avail%0d: count=%0d prepared=%b out=%h want 0/0/0",
                         i, count, prepared, out_packet);
            end
        end
        avail = 1'b0;
        enq_valid = 1'b1; enq_packet = 64'h99;
        tick();
        enq_valid = 1'b0;
        total++;
        if (out_packet !== 64'h99 || count !== CW'(1)) begin
            bad++;
            $display("FAIL empty_then_enq: out=%h count=%0d want 99/1", out_packet, count);
        end
        enq_valid = 1'b1; enq_packet = 64'h9A; avail = 1'b1;
        tick();
        enq_valid = 1'b0; avail = 1'b0;
        total++;
        if (out_packet !== 64'h9A || count !== CW'(1)) begin
            bad++;
            $display("FAIL empty_ptr_order: out=%h count=%0d want 9a/1", out_packet, count);
        end
        flush();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            enq_valid  = ($urandom_range(0, 9) < 6);
            avail      = ($urandom_range(0, 9) < 5);
            squash     = ($urandom_range(0, 24) == 0);
            enq_packet = {$urandom, $urandom};
            tick();
            total++;
            if (count !== exp_count() || prepared !== (model.size() != 0) ||
                out_packet !== exp_out() || enq_ready !== (model.size() != DEPTH)) begin
                bad++;
                $display("FAIL random_%0d: count=%0d out=%h ready=%b want %0d/%h/%b",
                         i, count, out_packet, enq_ready, exp_count(), exp_out(), model.size() != DEPTH);
            end
        end
        enq_valid = 1'b0; avail = 1'b0; squash = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order_fill();
        test_full();
        test_back_to_back();
        test_squash();
        test_async_reset();
        test_empty_avail();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
